// File: rtl/wb_rr_arb.sv
// N-master round-robin Wishbone arbiter onto one slave bus (x_*).
// Ports: wb_clk/wb_rst, m_* per-master buses (packed), x_* slave bus, grant, timeouts.
module wb_rr_arb #(
  parameter int N       = 4,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            wb_clk,
  input  logic            wb_rst,
  input  logic [N-1:0]    m_cyc,
  input  logic [N-1:0]    m_we,
  input  logic [4*N-1:0]  m_sel,
  input  logic [AW*N-1:0] m_adr,
  input  logic [DW*N-1:0] m_dat,
  output logic [N-1:0]    m_ack,
  output logic [N-1:0]    m_err,
  output logic [DW-1:0]   m_rdt,
  output logic            x_cyc,
  output logic            x_we,
  output logic [3:0]      x_sel,
  output logic [AW-1:0]   x_adr,
  output logic [DW-1:0]   x_dat,
  input  logic            x_ack,
  input  logic [DW-1:0]   x_rdt,
  output logic [N-1:0]    grant,
  output logic [7:0]      timeouts
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TLIM =
    (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
  localparam logic WD_ON = (TIMEOUT > 0);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  grant_q, grant_d;
  logic [IW-1:0] last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    tmo_q, tmo_d;

  logic          in_grant;
  logic          win_vld;
  logic [IW-1:0] win;
  logic          ack_ok;
  logic          tmo_hit;
  logic          abort;

  // Rotating priority: scan last+1, last+2, ... wrapping at N.
  always_comb begin
    logic [IW-1:0] cand;
    win_vld = 1'b0;
    win     = last_q;
    cand    = '0;
    for (int k = 1; k <= N; k++) begin
      cand = IW'((int'(last_q) + k) % N);
      if (!win_vld && m_cyc[cand]) begin
        win_vld = 1'b1;
        win     = cand;
      end
    end
  end

  // While granted, last_q holds the index of the granted master.
  assign in_grant = (state_q == GRANT);

  always_comb begin
    x_cyc = 1'b0;
    x_we  = 1'b0;
    x_sel = '0;
    x_adr = '0;
    x_dat = '0;
    if (in_grant) begin
      x_cyc = m_cyc[last_q];
      x_we  = m_we[last_q];
      x_sel = m_sel[4*last_q +: 4];
      x_adr = m_adr[AW*last_q +: AW];
      x_dat = m_dat[DW*last_q +: DW];
    end
  end

  assign abort   = in_grant && !m_cyc[last_q];
  assign ack_ok  = in_grant && x_cyc && x_ack;
  // Ack in the same cycle as the deadline wins over the error.
  assign tmo_hit = WD_ON && in_grant && x_cyc && !x_ack &&
                   (cnt_q == TLIM);

  assign m_ack    = ack_ok ? grant_q : '0;
  assign m_err    = tmo_hit ? grant_q : '0;
  assign m_rdt    = ack_ok ? x_rdt : '0;
  assign grant    = grant_q;
  assign timeouts = tmo_q;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    unique case (state_q)
      IDLE: begin
        if (win_vld) begin
          state_d = GRANT;
          grant_d = {{(N-1){1'b0}}, 1'b1} << win;
          last_d  = win;
          cnt_d   = '0;
        end
      end
      GRANT: begin
        if (abort || ack_ok || tmo_hit) begin
          state_d = IDLE;
          grant_d = '0;
          cnt_d   = '0;
          if (tmo_hit && tmo_q != 8'hFF) begin
            tmo_d = tmo_q + 8'd1;
          end
        end else if (WD_ON) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= IW'(N - 1);
      cnt_q   <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
    end
  end

endmodule

// File: tb/tb_wb_rr_arb.sv
// Bench for wb_rr_arb: vector table, arbitration sequences, watchdog,
// abort and reset; acks are checked against a queue of expected results.
module tb_wb_rr_arb;

  logic         clk;
  logic         rst;
  logic [3:0]   m_cyc;
  logic [3:0]   m_we;
  logic [15:0]  m_sel;
  logic [127:0] m_adr;
  logic [127:0] m_dat;
  logic [3:0]   m_ack;
  logic [3:0]   m_err;
  logic [31:0]  m_rdt;
  logic         x_cyc;
  logic         x_we;
  logic [3:0]   x_sel;
  logic [31:0]  x_adr;
  logic [31:0]  x_dat;
  logic         x_ack;
  logic [31:0]  x_rdt;
  logic [3:0]   grant;
  logic [7:0]   timeouts;

  wb_rr_arb #(.N(4), .AW(32), .DW(32), .TIMEOUT(8)) dut (
    .wb_clk(clk), .wb_rst(rst),
    .m_cyc(m_cyc), .m_we(m_we), .m_sel(m_sel),
    .m_adr(m_adr), .m_dat(m_dat),
    .m_ack(m_ack), .m_err(m_err), .m_rdt(m_rdt),
    .x_cyc(x_cyc), .x_we(x_we), .x_sel(x_sel),
    .x_adr(x_adr), .x_dat(x_dat),
    .x_ack(x_ack), .x_rdt(x_rdt),
    .grant(grant), .timeouts(timeouts)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input bit ok, input string name,
                     input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0h want %0h", name, act, exp);
  endtask

  // Slave: small RAM, acks ack_dly+1 cycles after it first sees x_cyc.
  logic [31:0] mem [16];
  int ack_dly = 0;
  int hold_cnt = 0;

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = '0;
    x_ack = 1'b0;
    x_rdt = '0;
  end

  always @(posedge clk) begin
    x_ack <= 1'b0;
    if (x_cyc && !x_ack) begin
      if (hold_cnt >= ack_dly) begin
        x_ack    <= 1'b1;
        hold_cnt <= 0;
        if (x_we) begin
          for (int b = 0; b < 4; b++)
            if (x_sel[b]) mem[x_adr[5:2]][8*b +: 8] <= x_dat[8*b +: 8];
        end else begin
          x_rdt <= mem[x_adr[5:2]];
        end
      end else begin
        hold_cnt <= hold_cnt + 1;
      end
    end else begin
      hold_cnt <= 0;
    end
  end

  typedef struct {
    int          m;
    bit          cr;
    logic [31:0] rdt;
  } exp_t;

  exp_t sb[$];

  always @(negedge clk) begin
    exp_t e;
    if (|m_ack) begin
      if (sb.size() == 0) begin
        chk(1'b0, "unexp_ack", 64'(m_ack), 64'(0));
      end else begin
        e = sb.pop_front();
        chk(m_ack == 4'(1 << e.m), "ack_sel", 64'(m_ack), 64'(1 << e.m));
        if (e.cr) chk(m_rdt == e.rdt, "rdt", 64'(m_rdt), 64'(e.rdt));
      end
    end
  end

  typedef struct {
    int          m;
    bit          we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic [31:0] rdt;
  } vec_t;

  vec_t vt[8];

  task automatic set_m(input int m, input bit we, input logic [31:0] adr,
                       input logic [31:0] dat, input logic [3:0] sel);
    m_we[m]           = we;
    m_adr[32*m +: 32] = adr;
    m_dat[32*m +: 32] = dat;
    m_sel[4*m +: 4]   = sel;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic txn(input vec_t v);
    exp_t e;
    bit got;
    e.m = v.m; e.cr = !v.we; e.rdt = v.rdt;
    @(posedge clk); #1;
    set_m(v.m, v.we, v.adr, v.dat, v.sel);
    m_cyc[v.m] = 1'b1;
    sb.push_back(e);
    @(negedge clk);
    chk(!x_cyc, "lat0", 64'(x_cyc), 64'(0));
    @(negedge clk);
    chk(x_cyc && x_we == v.we && x_sel == v.sel && grant == 4'(1 << v.m),
        "bus_ctl", {x_cyc, x_we, x_sel, grant}, {1'b1, v.we, v.sel, 4'(1 << v.m)});
    chk(x_adr == v.adr && x_dat == v.dat, "bus_data",
        {x_adr, x_dat}, {v.adr, v.dat});
    got = 1'b0;
    for (int w = 0; w < 20 && !got; w++) begin
      if (m_ack[v.m]) got = 1'b1;
      else @(negedge clk);
    end
    chk(got, "ack_wait", 64'(got), 64'(1));
    @(posedge clk); #1;
    m_cyc[v.m] = 1'b0;
    @(negedge clk);
    chk(!x_cyc && !x_we && x_sel == 0 && x_adr == 0 && x_dat == 0 && grant == 0,
        "idle_after", {x_cyc, x_we, x_sel, grant}, 64'(0));
  endtask

  task automatic serve(input logic [3:0] req, input int n,
                       input int exp[8], input bit rr);
    int got;
    int gi;
    logic [3:0] drop;
    logic [3:0] raise;
    logic [3:0] pg;
    bit pa;
    exp_t e;
    got = 0; gi = 0; raise = '0; pg = '0; pa = 1'b0;
    for (int k = 0; k < n; k++) begin
      e.m = exp[k]; e.cr = 1'b0; e.rdt = '0;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    m_cyc = m_cyc | req;
    for (int c = 0; c < 200 && got < n; c++) begin
      @(negedge clk);
      if (pa) chk(!x_cyc && grant == 0, "gap", {x_cyc, grant}, 64'(0));
      if (grant != 0 && pg == 0 && gi < n) begin
        chk(grant == 4'(1 << exp[gi]), "order", 64'(grant), 64'(1 << exp[gi]));
        gi++;
      end
      pg = grant;
      pa = |m_ack;
      if (|m_ack) got++;
      drop = m_ack;
      @(posedge clk); #1;
      m_cyc = (m_cyc & ~drop) | raise;
      raise = rr ? drop : 4'b0;
    end
    chk(got == n, "serve_done", 64'(got), 64'(n));
    m_cyc = '0;
  endtask

  initial begin
    int cnt;
    bit seen;
    exp_t e;
    vt[0] = '{0, 1'b1, 32'h8000_0020, 32'h1234_3456, 4'hF, 32'h0};
    vt[1] = '{0, 1'b1, 32'h8000_0010, 32'hcafe_cafe, 4'hF, 32'h0};
    vt[2] = '{3, 1'b0, 32'h8000_0010, 32'h0,         4'hF, 32'hcafe_cafe};
    vt[3] = '{2, 1'b1, 32'h8000_0004, 32'hdead_beef, 4'h3, 32'h0};
    vt[4] = '{1, 1'b0, 32'h8000_0020, 32'h0,         4'hF, 32'h1234_3456};
    vt[5] = '{1, 1'b0, 32'h8000_0004, 32'h0,         4'hF, 32'h0000_beef};
    vt[6] = '{2, 1'b1, 32'h8000_0004, 32'h1122_3344, 4'hC, 32'h0};
    vt[7] = '{0, 1'b0, 32'h8000_0004, 32'h0,         4'hF, 32'h1122_beef};

    rst = 1'b1;
    m_cyc = '0; m_we = '0; m_sel = '0; m_adr = '0; m_dat = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk(grant == 0 && !x_cyc && timeouts == 0, "reset_state",
        {grant, x_cyc, timeouts}, 64'(0));
    chk(m_ack == 0 && m_err == 0 && x_adr == 0, "reset_out",
        {m_ack, m_err, x_adr}, 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 8; i++) txn(vt[i]);

    do_reset();
    set_m(1, 1'b1, 32'h8000_0030, 32'h1111_1111, 4'hF);
    set_m(2, 1'b1, 32'h8000_0034, 32'h2222_2222, 4'hF);
    serve(4'b0110, 2, '{1, 2, 0, 0, 0, 0, 0, 0}, 1'b0);

    do_reset();
    for (int i = 0; i < 4; i++)
      set_m(i, 1'b0, 32'h8000_0000 + 32'(4 * i), 32'h0, 4'hF);
    serve(4'b1111, 6, '{0, 1, 2, 3, 0, 1, 0, 0}, 1'b1);

    ack_dly = 1000;
    @(posedge clk); #1;
    set_m(0, 1'b1, 32'h8000_0008, 32'h5555_5555, 4'hF);
    m_cyc[0] = 1'b1;
    cnt = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (x_cyc) cnt++;
      if (|m_err) break;
    end
    chk(m_err == 4'b0001, "err_bit", 64'(m_err), 64'(1));
    chk(cnt == 8, "err_cycle", 64'(cnt), 64'(8));
    @(posedge clk); #1;
    m_cyc = '0;
    @(negedge clk);
    chk(!x_cyc && grant == 0, "err_drop", {x_cyc, grant}, 64'(0));
    chk(timeouts == 8'd1, "tmo_cnt", 64'(timeouts), 64'(1));

    ack_dly = 6;
    e.m = 0; e.cr = 1'b0; e.rdt = '0;
    @(posedge clk); #1;
    m_cyc[0] = 1'b1;
    sb.push_back(e);
    cnt = 0; seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (x_cyc) cnt++;
      if (|m_err) seen = 1'b1;
      if (m_ack[0]) break;
    end
    chk(cnt == 8 && m_ack[0], "ack8_cycle", 64'(cnt), 64'(8));
    chk(!seen, "ack8_noerr", 64'(seen), 64'(0));
    @(posedge clk); #1;
    m_cyc = '0;
    @(negedge clk);
    chk(timeouts == 8'd1, "tmo_hold", 64'(timeouts), 64'(1));

    do_reset();
    ack_dly = 1000;
    set_m(0, 1'b0, 32'h8000_0000, 32'h0, 4'hF);
    set_m(2, 1'b0, 32'h8000_0020, 32'h0, 4'hF);
    @(posedge clk); #1;
    m_cyc = 4'b0101;
    cnt = 0;
    for (int c = 0; c < 10 && grant == 0; c++) @(negedge clk);
    chk(grant == 4'b0001, "abort_first", 64'(grant), 64'(1));
    @(posedge clk); #1;
    m_cyc[0] = 1'b0;
    @(negedge clk);
    chk(!x_cyc && m_ack == 0 && m_err == 0, "abort_xcyc",
        {x_cyc, m_ack, m_err}, 64'(0));
    e.m = 2; e.cr = 1'b1; e.rdt = 32'h1234_3456;
    sb.push_back(e);
    ack_dly = 0;
    @(negedge clk);
    chk(grant == 0, "abort_idle", 64'(grant), 64'(0));
    @(negedge clk);
    chk(grant == 4'b0100, "abort_next", 64'(grant), 64'(4));
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      if (m_ack[2]) seen = 1'b1;
      else @(negedge clk);
    end
    chk(seen, "abort_ack", 64'(seen), 64'(1));
    @(posedge clk); #1;
    m_cyc = '0;

    ack_dly = 1000;
    @(posedge clk); #1;
    m_cyc[2] = 1'b1;
    for (int c = 0; c < 10 && grant == 0; c++) @(negedge clk);
    chk(grant == 4'b0100, "rst_pre", 64'(grant), 64'(4));
    @(posedge clk); #1;
    rst = 1'b1;
    m_cyc = '0;
    @(posedge clk);
    @(negedge clk);
    chk(grant == 0 && !x_cyc, "rst_mid", {grant, x_cyc}, 64'(0));
    set_m(1, 1'b0, 32'h8000_0000, 32'h0, 4'hF);
    set_m(3, 1'b0, 32'h8000_0000, 32'h0, 4'hF);
    m_cyc = 4'b1010;
    ack_dly = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    serve(4'b0000, 2, '{1, 3, 0, 0, 0, 0, 0, 0}, 1'b0);

    repeat (3) @(negedge clk);
    chk(sb.size() == 0, "sb_empty", 64'(sb.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
